beep_pattern: RTL and testbench

BEEP_PATTERN -- requirements
Module: beep_pattern

---
 rtl/beep_pkg.sv | 24 ++
 rtl/tone_gen.sv | 60 ++++++
 rtl/beep_pattern.sv | 104 ++++++++++
 tb/tb_beep_pattern.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer pattern player: FSM encoding,
// default timing for a 50 MHz clock, and a counter-width helper.
package beep_pkg;

    // Pattern player states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    // Default timing constants for a 50 MHz clk.
    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned DEF_TONE_HALF = 25_000;     // 1 kHz tone
    localparam int unsigned DEF_ON_CYC    = 5_000_000;  // 100 ms burst
    localparam int unsigned DEF_OFF_CYC   = 5_000_000;  // 100 ms gap
    localparam int unsigned DEF_BEEP_NUM  = 3;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : beep_pkg

// File: rtl/tone_gen.sv
// Square-wave divider for the buzzer. While en is high the output starts
// at 1 and toggles every TONE_HALF cycles; en low forces 0 and clears
// the counter so the next enable starts a fresh tone.
module tone_gen
    import beep_pkg::*;
#(
    parameter int unsigned TONE_HALF = DEF_TONE_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic wave
);

    localparam int unsigned    CW       = cnt_width(TONE_HALF);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TONE_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wave_q, wave_d;
    logic          run_q, run_d;   // set once the first enabled edge has loaded wave=1

    // Next-state logic of the divider.
    always_comb begin
        // NOTE: every _d gets its hold value first so no branch can leave one unassigned (no latch).
        cnt_d  = cnt_q;
        wave_d = wave_q;
        run_d  = run_q;
        if (!en) begin
            cnt_d  = '0;
            wave_d = 1'b0;
            run_d  = 1'b0;
        end else if (!run_q) begin
            cnt_d  = '0;
            wave_d = 1'b1;
            run_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
            run_q  <= run_d;
        end
    end

    assign wave = wave_q;

endmodule : tone_gen

// File: rtl/beep_pattern.sv
// Plays BEEP_NUM tone bursts of ON_CYC cycles separated by OFF_CYC cycles
// of silence for each accepted key_flag. Triggers arriving while a pattern
// is playing are dropped.
module beep_pattern
    import beep_pkg::*;
#(
    parameter int unsigned TONE_HALF = DEF_TONE_HALF,
    parameter int unsigned ON_CYC    = DEF_ON_CYC,
    parameter int unsigned OFF_CYC   = DEF_OFF_CYC,
    parameter int unsigned BEEP_NUM  = DEF_BEEP_NUM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_flag,
    output logic beep,
    output logic busy
);

    localparam int unsigned   PHASE_MAX  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned   PW         = cnt_width(PHASE_MAX);
    localparam int unsigned   BW         = cnt_width(BEEP_NUM);
    localparam logic [PW-1:0] ON_LAST    = PW'(ON_CYC - 1);
    localparam logic [PW-1:0] OFF_LAST   = PW'(OFF_CYC - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BEEP_NUM - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;   // cycles spent in the current ON/OFF phase
    logic [BW-1:0] burst_q, burst_d;   // bursts already completed in this pattern
    logic          busy_q, busy_d;
    logic          tone_en;

    // Next-state, phase and burst bookkeeping.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (key_flag) begin
                    state_d = ON;
                    phase_d = '0;
                    burst_d = '0;
                end
            end
            ON: begin
                if (phase_q == ON_LAST) begin
                    phase_d = '0;
                    if (burst_q == BURST_LAST) begin
                        state_d = IDLE;   // last burst: no trailing silence
                        burst_d = '0;
                    end else begin
                        state_d = OFF;
                        burst_d = burst_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            OFF: begin
                if (phase_q == OFF_LAST) begin
                    state_d = ON;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                burst_d = '0;
            end
        endcase
        // Outputs are registered from the next state so they appear on the entry edge.
        busy_d  = (state_d != IDLE);
        tone_en = (state_d == ON);
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            burst_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            burst_q <= burst_d;
            busy_q  <= busy_d;
        end
    end

    tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tone_en),
        .wave  (beep)
    );

    assign busy = busy_q;

endmodule : beep_pattern

// File: tb/tb_beep_pattern.sv
// Bench for beep_pattern: two instances (BEEP_NUM=2 and BEEP_NUM=1) share
// clock, reset and key_flag. A directed table covers the basic pattern,
// hand-written sequences cover the multi-cycle corners, and a behavioural
// model derived from the pattern timing checks every cycle.
module tb_beep_pattern;

    localparam int unsigned TH   = 2;
    localparam int unsigned ONC  = 8;
    localparam int unsigned OFFC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_flag = 1'b0;
    logic beep_a, busy_a, beep_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: whether a pattern was accepted, and its key cycle.
    bit act_a = 1'b0, act_b = 1'b0;
    int t0_a = 0, t0_b = 0;

    typedef struct {
        logic key;
        logic beep_a;
        logic busy_a;
        logic beep_b;
        logic busy_b;
    } vec_t;

    vec_t vecs [23];

    always #5 clk = ~clk;

    beep_pattern #(
        .TONE_HALF (TH), .ON_CYC (ONC), .OFF_CYC (OFFC), .BEEP_NUM (2)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .key_flag (key_flag),
        .beep (beep_a), .busy (busy_a)
    );

    beep_pattern #(
        .TONE_HALF (TH), .ON_CYC (ONC), .OFF_CYC (OFFC), .BEEP_NUM (1)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .key_flag (key_flag),
        .beep (beep_b), .busy (busy_b)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected outputs at cycle c for a pattern whose key was seen at cycle t0.
    function automatic void model_out(input int bn, input bit act, input int t0,
                                      input int c, output bit b, output bit bz);
        int len;
        int r;
        int p;
        len = bn * ONC + (bn - 1) * OFFC;
        r   = c - t0;
        b   = 1'b0;
        bz  = 1'b0;
        if (act && r >= 1 && r <= len) begin
            bz = 1'b1;
            p  = (r - 1) % (ONC + OFFC);
            b  = (p < ONC) && (((p / TH) % 2) == 0);
        end
    endfunction

    // One clock cycle: drive key, sample mid-cycle, compare both DUTs with the model.
    task automatic run_cycle(input logic k);
        bit eb, ez;
        @(posedge clk);
        #1 key_flag = k;
        @(negedge clk);
        model_out(2, act_a, t0_a, cyc, eb, ez);
        check("model_a_beep", beep_a, eb);
        check("model_a_busy", busy_a, ez);
        if (k && !ez) begin act_a = 1'b1; t0_a = cyc; end
        model_out(1, act_b, t0_b, cyc, eb, ez);
        check("model_b_beep", beep_b, eb);
        check("model_b_busy", busy_b, ez);
        if (k && !ez) begin act_b = 1'b1; t0_b = cyc; end
        cyc++;
    endtask

    task automatic do_reset();
        key_flag = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_beep_a", beep_a, 1'b0);
        check("reset_busy_a", busy_a, 1'b0);
        check("reset_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;
        act_a = 1'b0;
        act_b = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] pat_beep_a, pat_busy_a, pat_beep_b, pat_busy_b, key_pass;
        int          starts;
        int          start2;
        logic        prev_busy;

        // Cycle 0 is the MSB of each pattern.
        pat_beep_a = 23'b0_11001100_0000_11001100_00;
        pat_busy_a = 23'b0_11111111_1111_11111111_00;
        pat_beep_b = 23'b0_11001100_0000_00000000_00;
        pat_busy_b = 23'b0_11111111_0000_00000000_00;
        for (int c = 0; c < 23; c++) begin
            vecs[c].key    = 1'b0;
            vecs[c].beep_a = pat_beep_a[22-c];
            vecs[c].busy_a = pat_busy_a[22-c];
            vecs[c].beep_b = pat_beep_b[22-c];
            vecs[c].busy_b = pat_busy_b[22-c];
        end

        // Pass 0: single trigger. Pass 1: extra triggers at 5, 10, 20 are ignored by dut_a.
        for (int pass = 0; pass < 2; pass++) begin
            key_pass = (pass == 0) ? 23'b1_00000000_0000_00000000_00
                                   : 23'b1_00001000_0100_00000001_00;
            for (int c = 0; c < 23; c++) vecs[c].key = key_pass[22-c];
            do_reset();
            for (int c = 0; c < 23; c++) begin
                run_cycle(vecs[c].key);
                check("tbl_beep_a", beep_a, vecs[c].beep_a);
                check("tbl_busy_a", busy_a, vecs[c].busy_a);
                if (pass == 0) begin
                    check("tbl_beep_b", beep_b, vecs[c].beep_b);
                    check("tbl_busy_b", busy_b, vecs[c].busy_b);
                end
            end
        end

        // Back-to-back: second trigger in the first idle cycle.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            run_cycle(c == 0 || c == 21);
            if (c == 21) check("b2b_busy_c21", busy_a, 1'b0);
            if (c == 22) begin
                check("b2b_beep_c22", beep_a, 1'b1);
                check("b2b_busy_c22", busy_a, 1'b1);
            end
        end

        // Reset asserted mid-burst at cycle 10.5, no resume after release.
        do_reset();
        for (int c = 0; c <= 10; c++) run_cycle(c == 0);
        check("pre_rst_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_beep", beep_a, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_hold_busy", busy_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        act_a = 1'b0;
        act_b = 1'b0;
        cyc   = 0;
        for (int c = 0; c < 25; c++) run_cycle(1'b0);
        check("post_rst_idle", busy_a, 1'b0);
        run_cycle(1'b1);
        run_cycle(1'b0);
        check("post_rst_retrigger", beep_a, 1'b1);

        // Held key: exactly two patterns, starting at cycles 1 and 22.
        do_reset();
        starts    = 0;
        start2    = -1;
        prev_busy = 1'b0;
        for (int c = 0; c < 50; c++) begin
            run_cycle(c <= 25);
            if (busy_a && !prev_busy) begin
                starts++;
                if (starts == 2) start2 = c;
            end
            prev_busy = busy_a;
        end
        check_int("held_pattern_count", starts, 2);
        check_int("held_second_start", start2, 22);

        // Random triggers against the model.
        do_reset();
        for (int i = 0; i < 600; i++) run_cycle($urandom_range(0, 7) == 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_beep_pattern
